// File: rtl/snax_gemmx_csr_manager.sv
// CSR front-end for the GEMMX accelerator: stages config writes, launches them as one set, serves reads.
// Optional launch counter at the PC address is enabled by defining SNAX_GEMMX_CSR_PERF_EN.
module snax_gemmx_csr_manager #(
   parameter int unsigned RegRWCount   = 10,
   parameter int unsigned RegROCount   = 2,
   parameter int unsigned RegDataWidth = 32,
   parameter int unsigned RegAddrWidth = 32
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic [RegAddrWidth-1:0]                  csr_req_addr_i,
   input  logic [RegDataWidth-1:0]                  csr_req_data_i,
   input  logic                                     csr_req_write_i,
   input  logic                                     csr_req_valid_i,
   output logic                                     csr_req_ready_o,
   output logic [RegDataWidth-1:0]                  csr_rsp_data_o,
   output logic                                     csr_rsp_valid_o,
   input  logic                                     csr_rsp_ready_i,
   output logic [RegRWCount-1:0][RegDataWidth-1:0]  csr_reg_set_o,
   output logic                                     csr_reg_set_valid_o,
   input  logic                                     csr_reg_set_ready_i,
   input  logic [RegROCount-1:0][RegDataWidth-1:0]  csr_reg_ro_set_i
);

   localparam logic [RegAddrWidth-1:0] AddrL  = RegAddrWidth'(RegRWCount);
   localparam logic [RegAddrWidth-1:0] AddrSt = RegAddrWidth'(RegRWCount + RegROCount + 1);
   localparam logic [RegAddrWidth-1:0] AddrPc = RegAddrWidth'(RegRWCount + RegROCount + 2);

   // csr_reg_set_valid_o is the state flop itself, so the FSM state is directly observable.
   typedef enum logic {
      Idle    = 1'b0,
      Pending = 1'b1
   } state_e;

   state_e                                  state_q;
   logic [RegRWCount-1:0][RegDataWidth-1:0] s_q;
   logic [RegRWCount-1:0][RegDataWidth-1:0] b_q;
   logic                                    rsp_valid_q;
   logic [RegDataWidth-1:0]                 rsp_data_q;
   logic [RegDataWidth-1:0]                 rd_data;
   logic [RegDataWidth-1:0]                 perf_val;
   logic                                    is_launch;
   logic                                    rsp_stall;
   logic                                    req_fire;

   // All three channels transfer on a cycle where valid and ready are both high; a source
   // holds valid and payload stable until that cycle, and ready never depends on valid.
   assign is_launch       = csr_req_write_i && (csr_req_addr_i == AddrL);
   assign rsp_stall       = rsp_valid_q && !csr_rsp_ready_i;
   assign csr_req_ready_o = !rsp_stall && !(is_launch && (state_q == Pending));
   assign req_fire        = csr_req_valid_i && csr_req_ready_o;

   assign csr_reg_set_o       = b_q;
   assign csr_reg_set_valid_o = (state_q == Pending);
   assign csr_rsp_data_o      = rsp_data_q;
   assign csr_rsp_valid_o     = rsp_valid_q;

`ifdef SNAX_GEMMX_CSR_PERF_EN
   logic [RegDataWidth-1:0] perf_q;
   logic                    set_fire;

   assign set_fire = (state_q == Pending) && csr_reg_set_ready_i;
   assign perf_val = perf_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         perf_q <= '0;
      end else if (set_fire) begin
         perf_q <= perf_q + RegDataWidth'(1);
      end
   end
`else
   assign perf_val = '0;
`endif

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < RegRWCount; i++) begin
         if (csr_req_addr_i == RegAddrWidth'(i)) rd_data = s_q[i];
      end
      // RO values are sampled here, at acceptance, not when the response is consumed.
      for (int j = 0; j < RegROCount; j++) begin
         if (csr_req_addr_i == RegAddrWidth'(RegRWCount + 1 + j)) rd_data = csr_reg_ro_set_i[j];
      end
      if (csr_req_addr_i == AddrSt) begin
         rd_data[0] = (state_q == Pending);
         rd_data[1] = rsp_valid_q;
      end
      if (csr_req_addr_i == AddrPc) rd_data = perf_val;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= Idle;
         s_q         <= '0;
         b_q         <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         case (state_q)
            Idle: begin
               if (req_fire && is_launch) begin
                  b_q     <= s_q;
                  state_q <= Pending;
               end
            end
            Pending: begin
               if (csr_reg_set_ready_i) state_q <= Idle;
            end
         endcase

         if (req_fire && csr_req_write_i) begin
            for (int i = 0; i < RegRWCount; i++) begin
               if (csr_req_addr_i == RegAddrWidth'(i)) s_q[i] <= csr_req_data_i;
            end
         end

         if (req_fire && !csr_req_write_i) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rd_data;
         end else if (csr_rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_snax_gemmx_csr_manager.sv
// Self-checking bench for snax_gemmx_csr_manager: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based behavioural model.
module tb_snax_gemmx_csr_manager;

   localparam int NRW = 10;
   localparam int NRO = 2;
   localparam logic [31:0] A_L  = 32'd10;
   localparam logic [31:0] A_ST = 32'd13;
   localparam logic [31:0] A_PC = 32'd14;
`ifdef SNAX_GEMMX_CSR_PERF_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   logic                      clk_i = 1'b0;
   logic                      rst_ni = 1'b0;
   logic [31:0]               csr_req_addr_i = '0;
   logic [31:0]               csr_req_data_i = '0;
   logic                      csr_req_write_i = 1'b0;
   logic                      csr_req_valid_i = 1'b0;
   logic                      csr_req_ready_o;
   logic [31:0]               csr_rsp_data_o;
   logic                      csr_rsp_valid_o;
   logic                      csr_rsp_ready_i = 1'b0;
   logic [NRW-1:0][31:0]      csr_reg_set_o;
   logic                      csr_reg_set_valid_o;
   logic                      csr_reg_set_ready_i = 1'b0;
   logic [NRO-1:0][31:0]      csr_reg_ro_set_i = '0;

   int total = 0;
   int bad = 0;

   // reference model state
   logic [31:0] m_s [NRW];
   logic [31:0] m_b [NRW];
   logic        m_pending;
   logic [31:0] m_perf;
   logic [31:0] exp_q [$];
   logic [31:0] ro_v [NRO];

   snax_gemmx_csr_manager #(
      .RegRWCount  (NRW),
      .RegROCount  (NRO),
      .RegDataWidth(32),
      .RegAddrWidth(32)
   ) dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .csr_req_addr_i     (csr_req_addr_i),
      .csr_req_data_i     (csr_req_data_i),
      .csr_req_write_i    (csr_req_write_i),
      .csr_req_valid_i    (csr_req_valid_i),
      .csr_req_ready_o    (csr_req_ready_o),
      .csr_rsp_data_o     (csr_rsp_data_o),
      .csr_rsp_valid_o    (csr_rsp_valid_o),
      .csr_rsp_ready_i    (csr_rsp_ready_i),
      .csr_reg_set_o      (csr_reg_set_o),
      .csr_reg_set_valid_o(csr_reg_set_valid_o),
      .csr_reg_set_ready_i(csr_reg_set_ready_i),
      .csr_reg_ro_set_i   (csr_reg_ro_set_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NRW; i++) begin
         m_s[i] = '0;
         m_b[i] = '0;
      end
      m_pending = 1'b0;
      m_perf    = '0;
      exp_q.delete();
   endtask

   task automatic do_reset(input int n);
      @(negedge clk_i);
      rst_ni              = 1'b0;
      csr_req_valid_i     = 1'b0;
      csr_rsp_ready_i     = 1'b0;
      csr_reg_set_ready_i = 1'b0;
      repeat (n) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      model_reset();
      check("rst_set_valid", {31'b0, csr_reg_set_valid_o}, 32'd0);
      check("rst_rsp_valid", {31'b0, csr_rsp_valid_o}, 32'd0);
      check("rst_rsp_data", csr_rsp_data_o, 32'd0);
   endtask

   // One bus cycle: drive, compare against the model, then advance the model across the edge.
   task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic rr, input logic sr);
      logic        exp_ready;
      logic        acc;
      logic [31:0] rd;
      @(negedge clk_i);
      csr_req_valid_i     = v;
      csr_req_write_i     = w;
      csr_req_addr_i      = a;
      csr_req_data_i      = d;
      csr_rsp_ready_i     = rr;
      csr_reg_set_ready_i = sr;
      for (int j = 0; j < NRO; j++) csr_reg_ro_set_i[j] = ro_v[j];
      #1;
      exp_ready = !((exp_q.size() != 0) && !rr) && !(w && (a == A_L) && m_pending);
      if (v) check("req_ready", {31'b0, csr_req_ready_o}, {31'b0, exp_ready});
      check("rsp_valid", {31'b0, csr_rsp_valid_o}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) check("rsp_data", csr_rsp_data_o, exp_q[0]);
      check("set_valid", {31'b0, csr_reg_set_valid_o}, {31'b0, m_pending});
      for (int i = 0; i < NRW; i++) check($sformatf("set_o[%0d]", i), csr_reg_set_o[i], m_b[i]);

      if (a < NRW) rd = m_s[a];
      else if (a > A_L && a < A_ST) rd = ro_v[a - A_L - 1];
      else if (a == A_ST) rd = {30'b0, exp_q.size() != 0, m_pending};
      else if (a == A_PC) rd = PERF_EN ? m_perf : 32'd0;
      else rd = 32'd0;

      @(posedge clk_i);
      acc = v && exp_ready;
      if ((exp_q.size() != 0) && rr) void'(exp_q.pop_front());
      if (m_pending && sr) begin
         m_pending = 1'b0;
         m_perf    = m_perf + 32'd1;
      end
      if (acc && w) begin
         if (a < NRW) m_s[a] = d;
         else if (a == A_L) begin
            m_b       = m_s;
            m_pending = 1'b1;
         end
      end
      if (acc && !w) exp_q.push_back(rd);
      #1;
   endtask

   initial begin
      logic [31:0] ra;
      int          r;
      for (int j = 0; j < NRO; j++) ro_v[j] = '0;
      model_reset();
      do_reset(2);

      // single launch with immediate ready
      step(1, 1, 0, 32'h10, 1, 1);
      step(1, 1, 1, 32'h20, 1, 1);
      step(1, 1, A_L, 32'hDEAD, 1, 1);
      check("l1_valid", {31'b0, csr_reg_set_valid_o}, 32'd1);
      check("l1_set0", csr_reg_set_o[0], 32'h10);
      check("l1_set1", csr_reg_set_o[1], 32'h20);
      step(0, 0, 0, 0, 1, 1);
      check("l1_done", {31'b0, csr_reg_set_valid_o}, 32'd0);

      // back-pressured launch, staging write during the wait
      step(1, 1, A_L, 0, 1, 0);
      for (int k = 0; k < 5; k++) step(k == 2, 1, 0, 32'h99, 1, 0);
      check("bp_set0", csr_reg_set_o[0], 32'h10);
      check("bp_valid", {31'b0, csr_reg_set_valid_o}, 32'd1);
      step(0, 0, 0, 0, 1, 1);
      check("bp_done", {31'b0, csr_reg_set_valid_o}, 32'd0);

      // second launch blocked while pending, including the handshake cycle
      step(1, 1, A_L, 0, 1, 0);
      step(1, 1, A_L, 0, 1, 0);
      check("l2_blocked", {31'b0, csr_req_ready_o}, 32'd0);
      step(1, 1, A_L, 0, 1, 1);
      step(1, 1, A_L, 0, 1, 0);
      check("l2_valid", {31'b0, csr_reg_set_valid_o}, 32'd1);
      check("l2_set0", csr_reg_set_o[0], 32'h99);
      step(0, 0, 0, 0, 1, 1);

      // RO read held under response back-pressure
      ro_v[0] = 32'hABCD;
      step(1, 0, A_L + 1, 0, 0, 0);
      ro_v[0] = 32'h1111;
      for (int k = 0; k < 3; k++) begin
         step(1, 0, 0, 0, 0, 0);
         check("ro_hold", csr_rsp_data_o, 32'hABCD);
      end
      step(0, 0, 0, 0, 1, 0);
      check("ro_drained", {31'b0, csr_rsp_valid_o}, 32'd0);

      // reset while a launch is pending
      step(1, 1, A_L, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      do_reset(1);
      step(0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0);
      check("rst_s0_valid", {31'b0, csr_rsp_valid_o}, 32'd1);
      check("rst_s0_data", csr_rsp_data_o, 32'd0);
      step(0, 0, 0, 0, 1, 0);

      // launch counter
      do_reset(1);
      for (int k = 0; k < 3; k++) begin
         step(1, 1, A_L, 0, 1, 1);
         step(0, 0, 0, 0, 1, 1);
      end
      step(1, 0, A_PC, 0, 0, 0);
      check("perf_count", csr_rsp_data_o, PERF_EN ? 32'd3 : 32'd0);
      step(0, 0, 0, 0, 1, 0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) do_reset(1);
         for (int j = 0; j < NRO; j++) ro_v[j] = $urandom;
         r  = $urandom_range(0, 19);
         ra = (r >= 16) ? (32'hFFFF_0000 | 32'(r)) : 32'(r);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra, $urandom,
              $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/snax_gemmx_csr_manager.md
SNAX_GEMMX_CSR_MANAGER -- requirements
Module: snax_gemmx_csr_manager

Interface
REQ-001 SHALL have parameter RegRWCount, default 10, number of RW config registers forwarded to the accelerator.
REQ-002 SHALL have parameter RegROCount, default 2, number of RO status registers read from the accelerator.
REQ-003 SHALL have parameter RegDataWidth, default 32, register width.
REQ-004 SHALL have parameter RegAddrWidth, default 32, request address width.
REQ-005 SHALL have port clk_i  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port csr_req_addr_i  input  RegAddrWidth  core request register index.
REQ-008 SHALL have port csr_req_data_i  input  RegDataWidth  write data.
REQ-009 SHALL have port csr_req_write_i  input  1  1 = write, 0 = read.
REQ-010 SHALL have ports csr_req_valid_i input 1 and csr_req_ready_o output 1, the request handshake.
REQ-011 SHALL have ports csr_rsp_data_o output RegDataWidth, csr_rsp_valid_o output 1 and csr_rsp_ready_i input 1, the read response.
REQ-012 SHALL have port csr_reg_set_o  output  RegRWCount x RegDataWidth  launched config set.
REQ-013 SHALL have ports csr_reg_set_valid_o output 1 and csr_reg_set_ready_i input 1, the launch handshake.
REQ-014 SHALL have port csr_reg_ro_set_i  input  RegROCount x RegDataWidth  accelerator status, sampled at read time.

Function
REQ-015 SHALL decode addresses as follows:
- 0..RegRWCount-1: staging registers S[i].
- RegRWCount (L): launch register.
- L+1..L+RegROCount: RO registers.
- L+RegROCount+1 (ST): status register, bit0 = launch pending, bit1 = response pending.
- L+RegROCount+2 (PC): perf counter.
REQ-016 SHALL accept a request when csr_req_valid_i and csr_req_ready_o are both 1 in the same cycle.
REQ-017 SHALL update S[i] with csr_req_data_i on the cycle an accepted write to index i is seen; S[i] SHALL NOT affect csr_reg_set_o until a launch.
REQ-018 SHALL, on an accepted write to L, copy all S into the launch buffer B and enter state PENDING; the write data is ignored.
REQ-019 SHALL drive csr_reg_set_o from B and assert csr_reg_set_valid_o exactly while in PENDING, starting the cycle after the L write is accepted.
REQ-020 SHALL hold B and csr_reg_set_valid_o stable until csr_reg_set_ready_i = 1, then return to IDLE on the next edge.
REQ-021 SHALL use two states, IDLE and PENDING, with no other transitions than IDLE->PENDING (L write) and PENDING->IDLE (launch handshake).
REQ-022 SHALL drive csr_req_ready_o = 0 for an L write while in PENDING, including the handshake cycle; the L write is accepted on the first cycle in IDLE.
REQ-023 SHALL keep accepting S writes and all reads while in PENDING; these SHALL NOT disturb B.
REQ-024 SHALL register read data on acceptance and assert csr_rsp_valid_o on the next cycle, holding data until csr_rsp_ready_i = 1.
REQ-025 SHALL allow one outstanding read: csr_req_ready_o = 0 for all requests while csr_rsp_valid_o = 1 and csr_rsp_ready_i = 0.
REQ-026 SHALL return S[i] for reads of RW indices, 0 for L, the csr_reg_ro_set_i value sampled at acceptance for RO indices, and 0 for out-of-range indices.
REQ-027 SHALL ignore writes to RO, ST, PC and out-of-range indices and produce no response for any write.

Reset
REQ-028 SHALL, while rst_ni = 0 at a clock edge, clear S, B and the counter, enter IDLE, and drive csr_reg_set_valid_o = 0, csr_rsp_valid_o = 0 and csr_rsp_data_o = 0.
REQ-029 SHALL drop a pending launch or response on reset without completing its handshake.

Configuration
REQ-030 SHALL, when SNAX_GEMMX_CSR_PERF_EN is defined, count completed launch handshakes in a RegDataWidth wrapping counter readable at PC.
REQ-031 SHALL, when SNAX_GEMMX_CSR_PERF_EN is undefined, implement no counter and return 0 for reads of PC.

Verification
REQ-032 SHALL cover: write S[0]=0x10, S[1]=0x20, then L, with ready_i=1 -> valid_o high for one cycle with set_o[0]=0x10 and set_o[1]=0x20.
REQ-033 SHALL cover: ready_i held 0 for 5 cycles, S[0]=0x99 written during the wait -> set_o[0] stays 0x10 and valid_o stays high until ready_i=1.
REQ-034 SHALL cover: second L write during PENDING -> csr_req_ready_o=0 until the first handshake completes, then a second launch issues with the new S.
REQ-035 SHALL cover: read of L+1 with ro_set_i[0]=0xABCD and rsp_ready_i=0 for 3 cycles -> rsp_data_o=0xABCD held and csr_req_ready_o=0 throughout.
REQ-036 SHALL cover: rst_ni=0 during PENDING -> valid_o=0 next cycle and S[0] reads back 0.
REQ-037 SHALL cover: with PERF_EN defined, 3 launches then a read of PC returns 3; with PERF_EN undefined, the same read returns 0.
